// File: rtl/sub_top_onchip_mem_arbiter.sv
// sub_top_onchip_mem_arbiter: round-robin two-master arbiter with burst hold for a single-port on-chip RAM.
// Define ONCHIP_ARB_STATS_EN to add grant/wait statistics counters.
module sub_top_onchip_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   m0_address,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_readdatavalid,
  input  logic [AW-1:0]   m1_address,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_readdatavalid,
  output logic [AW-1:0]   ram_address,
  output logic [DW/8-1:0] ram_byteenable,
  output logic            ram_chipselect,
  output logic            ram_write,
  output logic [DW-1:0]   ram_writedata,
  output logic            ram_clken,
  input  logic [DW-1:0]   ram_readdata
`ifdef ONCHIP_ARB_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_grant0,
  output logic [31:0]     stat_grant1,
  output logic [31:0]     stat_wait1
`endif
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [3:0] HMAX = 4'(HOLD_MAX);
  state_t state, state_n;
  logic last_owner, last_owner_n;
  logic [3:0] hold_cnt, hold_n;
  logic rd_valid, rd_valid_n, rd_port;
  logic req0, req1, grant0, grant1, grant, sel, wr_sel;
  // grant1 is decided first; m0 takes whatever is left, reset masks both
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    grant1 = 1'b0;
    if (reset_n)
      grant1 = (req0 & req1) ? (state == IDLE ? ~last_owner :
                                state == OWN0 ? hold_cnt >= HMAX : hold_cnt < HMAX) : req1;
    grant0 = reset_n & req0 & ~grant1;
    grant = grant0 | grant1;
    sel = grant1;
    wr_sel = grant & (sel ? m1_write : m0_write);
    state_n = grant1 ? OWN1 : grant0 ? OWN0 : IDLE;
    last_owner_n = grant ? sel : last_owner;
    hold_n = !grant ? 4'd0 : (sel != last_owner) ? 4'd1 : (hold_cnt >= HMAX) ? HMAX : hold_cnt + 4'd1;
    rd_valid_n = grant & ~wr_sel;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      last_owner <= 1'b1;
      hold_cnt <= 4'd0;
      rd_valid <= 1'b0;
      rd_port <= 1'b0;
    end else begin
      state <= state_n;
      last_owner <= last_owner_n;
      hold_cnt <= hold_n;
      rd_valid <= rd_valid_n;
      rd_port <= sel;
    end
  assign m0_waitrequest = req0 & ~grant0 & reset_n;
  assign m1_waitrequest = req1 & ~grant1 & reset_n;
  assign m0_readdata = ram_readdata;
  assign m1_readdata = ram_readdata;
  assign m0_readdatavalid = reset_n & rd_valid & ~rd_port;
  assign m1_readdatavalid = reset_n & rd_valid & rd_port;
  assign ram_address = sel ? m1_address : m0_address;
  assign ram_byteenable = wr_sel ? (sel ? m1_byteenable : m0_byteenable) : '1;
  assign ram_chipselect = grant;
  assign ram_write = wr_sel;
  assign ram_writedata = sel ? m1_writedata : m0_writedata;
  assign ram_clken = 1'b1;
`ifdef ONCHIP_ARB_STATS_EN
  always_ff @(posedge clk)
    if (!reset_n || stat_clr) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_wait1 <= '0;
    end else begin
      if (grant0 && ~&stat_grant0) stat_grant0 <= stat_grant0 + 32'd1;
      if (grant1 && ~&stat_grant1) stat_grant1 <= stat_grant1 + 32'd1;
      if (m1_waitrequest && ~&stat_wait1) stat_wait1 <= stat_wait1 + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sub_top_onchip_mem_arbiter.sv
// tb_sub_top_onchip_mem_arbiter: directed self-checking bench with a behavioural RAM behind the arbiter.
// Build with ONCHIP_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_sub_top_onchip_mem_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [15:0] m0_address = '0, m1_address = '0, ram_address;
  logic [3:0] m0_byteenable = '0, m1_byteenable = '0, ram_byteenable;
  logic m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0, m0_readdata, m1_readdata, ram_writedata, ram_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic ram_chipselect, ram_write, ram_clken;
`ifdef ONCHIP_ARB_STATS_EN
  logic stat_clr = 1'b0;
  logic [31:0] stat_grant0, stat_grant1, stat_wait1;
`endif
  int checks = 0, errors = 0;
  logic [31:0] mem [0:65535];
  logic [15:0] addr_q = '0;

  sub_top_onchip_mem_arbiter dut (
`ifdef ONCHIP_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_wait1(stat_wait1),
`endif
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // RAM with registered address and unregistered q
  always @(posedge clk) begin
    if (ram_chipselect && ram_write)
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
    addr_q <= ram_address;
  end
  assign ram_readdata = mem[addr_q];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return i == 16 ? 32'hDEADBEEF : i == 32 ? 32'hAABB3344 : (32'hA5000000 | 32'(i));
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls, nv, derr;
    logic exp_w0, exp_w1;
    for (int i = 0; i < 65536; i++) mem[i] = 32'hA5000000 | 32'(i);
    mem[16] = 32'hDEADBEEF;
    mem[32] = 32'hAABBCCDD;
    m0_read = 1'b1;
    m1_read = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rst_wait0", 32'(m0_waitrequest), 32'd0);
    check("rst_wait1", 32'(m1_waitrequest), 32'd0);
    check("rst_cs", 32'(ram_chipselect), 32'd0);
    check("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    check("clken", 32'(ram_clken), 32'd1);
    m0_read = 1'b0;
    m1_read = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    // single read
    m0_read = 1'b1;
    m0_address = 16'h0010;
    @(negedge clk);
    check("rd_wait0", 32'(m0_waitrequest), 32'd0);
    check("rd_cs", 32'(ram_chipselect), 32'd1);
    check("rd_addr", 32'(ram_address), 32'h10);
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    check("rd_valid0", 32'(m0_readdatavalid), 32'd1);
    check("rd_valid1", 32'(m1_readdatavalid), 32'd0);
    check("rd_data", m0_readdata, 32'hDEADBEEF);
    // partial write then read-back
    next_cycle();
    m0_write = 1'b1;
    m0_address = 16'h0020;
    m0_writedata = 32'h11223344;
    m0_byteenable = 4'b0011;
    @(negedge clk);
    check("wr_write", 32'(ram_write), 32'd1);
    check("wr_be", 32'(ram_byteenable), 32'h3);
    next_cycle();
    m0_write = 1'b0;
    m0_read = 1'b1;
    @(negedge clk);
    check("wr_no_valid", 32'(m0_readdatavalid), 32'd0);
    check("rb_write", 32'(ram_write), 32'd0);
    check("rb_be", 32'(ram_byteenable), 32'hF);
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    check("rb_valid", 32'(m0_readdatavalid), 32'd1);
    check("rb_data", m0_readdata, 32'hAABB3344);
    // contention from reset: m0 x4, m1 x4, ...
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    m0_read = 1'b1;
    m1_read = 1'b1;
    m0_address = 16'h0010;
    m1_address = 16'h0020;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      exp_w0 = ((c / 4) % 2) == 1;
      exp_w1 = !exp_w0;
      check($sformatf("rr_wait0_c%0d", c), 32'(m0_waitrequest), 32'(exp_w0));
      check($sformatf("rr_wait1_c%0d", c), 32'(m1_waitrequest), 32'(exp_w1));
      if (c > 0)
        check($sformatf("rr_valid1_c%0d", c), 32'(m1_readdatavalid), 32'((((c - 1) / 4) % 2) == 1));
      next_cycle();
    end
    m0_read = 1'b0;
    m1_read = 1'b0;
`ifdef ONCHIP_ARB_STATS_EN
    @(negedge clk);
    check("stat_grant0", stat_grant0, 32'd12);
    check("stat_grant1", stat_grant1, 32'd12);
    check("stat_wait1", stat_wait1, 32'd12);
    next_cycle();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    @(negedge clk);
    check("clr_grant0", stat_grant0, 32'd0);
    check("clr_grant1", stat_grant1, 32'd0);
    check("clr_wait1", stat_wait1, 32'd0);
`endif
    next_cycle();
    next_cycle();
    // m1 streams alone
    stalls = 0;
    nv = 0;
    derr = 0;
    m1_read = 1'b1;
    m1_address = 16'h0000;
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      if (i < 256 && m1_waitrequest) stalls++;
      if (m1_readdatavalid) begin
        if (m1_readdata !== exp_data(nv)) derr++;
        nv++;
      end
      next_cycle();
      if (i < 255) m1_address = 16'(i + 1);
      else m1_read = 1'b0;
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_valids", 32'(nv), 32'd256);
    check("stream_data_errs", 32'(derr), 32'd0);
    // reset drops an in-flight read
    next_cycle();
    m1_read = 1'b1;
    m1_address = 16'h0005;
    @(negedge clk);
    check("inflight_wait1", 32'(m1_waitrequest), 32'd0);
    reset_n = 1'b0;
    m1_read = 1'b0;
    @(negedge clk);
    check("inflight_dropped", 32'(m1_readdatavalid), 32'd0);
    check("inreset_cs", 32'(ram_chipselect), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    m0_read = 1'b1;
    m1_read = 1'b1;
    @(negedge clk);
    check("tie_wait0", 32'(m0_waitrequest), 32'd0);
    check("tie_wait1", 32'(m1_waitrequest), 32'd1);
    next_cycle();
    m0_read = 1'b0;
    m1_read = 1'b0;
    @(negedge clk);
    check("tie_valid0", 32'(m0_readdatavalid), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
